// File: rtl/infer_seq_ctrl.sv
// Serial MNIST inference sequencer: snapshots an 8x8 binary image, walks a signed weight ROM per class,
// tracks best/second-best scores and reports the winning digit with a margin. Option: INFER_BIAS_EN.
module infer_seq_ctrl #(
  parameter int N_PIX     = 64,
  parameter int N_CLASS   = 10,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16,
  parameter int AW        = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [N_PIX-1:0]     im,
  output logic [AW-1:0]        w_addr,
  input  logic [W_WIDTH-1:0]   w_data,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           digit,
  output logic [15:0]          confidence
);

`ifdef INFER_BIAS_EN
  localparam int BIAS_OFF = 1;
`else
  localparam int BIAS_OFF = 0;
`endif
  // Per class: an optional bias slot (sub 0) followed by one slot per pixel.
  localparam int SUBS  = N_PIX + BIAS_OFF;
  localparam int SUB_W = $clog2(SUBS);
  localparam int CLS_W = $clog2(N_CLASS);
  localparam int PIX_W = $clog2(N_PIX);

  localparam logic [SUB_W-1:0]            SUB_LAST = SUB_W'(SUBS - 1);
  localparam logic [CLS_W-1:0]            CLS_LAST = CLS_W'(N_CLASS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH:0]          SAT      = (ACC_WIDTH+1)'(65535);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                       state;
  logic [N_PIX-1:0]             shadow;
  logic                         iss_act;
  logic [CLS_W-1:0]             iss_cls;
  logic [SUB_W-1:0]             iss_sub;
  logic                         v1;
  logic [CLS_W-1:0]             cls1;
  logic [SUB_W-1:0]             sub1;
  logic                         cmp_v;
  logic [CLS_W-1:0]             cmp_cls;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  best;
  logic signed [ACC_WIDTH-1:0]  second;
  logic [CLS_W-1:0]             best_idx;

  logic signed [ACC_WIDTH-1:0]  w_ext;
  logic signed [ACC_WIDTH-1:0]  term;
  logic [PIX_W-1:0]             pix_idx;
  logic                         is_bias;
  logic [ACC_WIDTH:0]           margin;

  function automatic logic [AW-1:0] addr_of(input logic [CLS_W-1:0] c, input logic [SUB_W-1:0] s);
`ifdef INFER_BIAS_EN
    if (s == '0) return AW'(N_CLASS * N_PIX) + AW'(c);
    return AW'(c) * AW'(N_PIX) + AW'(s) - AW'(1);
`else
    return AW'(c) * AW'(N_PIX) + AW'(s);
`endif
  endfunction

  always_comb begin
    w_ext   = {{(ACC_WIDTH-W_WIDTH){w_data[W_WIDTH-1]}}, w_data};
    pix_idx = PIX_W'(sub1 - SUB_W'(BIAS_OFF));
`ifdef INFER_BIAS_EN
    is_bias = (sub1 == '0);
`else
    is_bias = 1'b0;
`endif
    term    = (is_bias || shadow[pix_idx]) ? w_ext : '0;
    // Sign-extended by one bit so best - second can never wrap negative.
    margin  = {best[ACC_WIDTH-1], best} - {second[ACC_WIDTH-1], second};
  end

  // NOTE: non-blocking assignments let the compare stage read the finished class score from acc on the
  // same edge that acc is reloaded for the next class, so classes follow each other with no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the shadow image and score registers are reset with the rest so an aborted run leaves nothing behind.
      state      <= S_IDLE;
      shadow     <= '0;
      iss_act    <= 1'b0;
      iss_cls    <= '0;
      iss_sub    <= '0;
      v1         <= 1'b0;
      cls1       <= '0;
      sub1       <= '0;
      cmp_v      <= 1'b0;
      cmp_cls    <= '0;
      acc        <= '0;
      best       <= '0;
      second     <= '0;
      best_idx   <= '0;
      w_addr     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      digit      <= '0;
      confidence <= '0;
    end else begin
      done  <= 1'b0;
      v1    <= 1'b0;
      cmp_v <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            shadow  <= im;
            busy    <= 1'b1;
            iss_act <= 1'b1;
            iss_cls <= '0;
            iss_sub <= '0;
            w_addr  <= addr_of('0, '0);
          end
        end
        S_RUN: begin
          // Issue stage: the address on w_addr now returns data next cycle.
          if (iss_act) begin
            v1   <= 1'b1;
            cls1 <= iss_cls;
            sub1 <= iss_sub;
            if (iss_sub == SUB_LAST) begin
              if (iss_cls == CLS_LAST) begin
                iss_act <= 1'b0;
              end else begin
                iss_cls <= iss_cls + 1'b1;
                iss_sub <= '0;
                w_addr  <= addr_of(iss_cls + 1'b1, '0);
              end
            end else begin
              iss_sub <= iss_sub + 1'b1;
              w_addr  <= addr_of(iss_cls, iss_sub + 1'b1);
            end
          end
          // Accumulate stage: first slot of a class reloads instead of adding.
          if (v1) begin
            acc     <= (sub1 == '0) ? term : acc + term;
            cmp_v   <= (sub1 == SUB_LAST);
            cmp_cls <= cls1;
          end
          // Compare stage: strict comparisons keep the lower index on ties.
          if (cmp_v) begin
            if (cmp_cls == '0) begin
              best     <= acc;
              best_idx <= '0;
              second   <= ACC_MIN;
            end else if (acc > best) begin
              second   <= best;
              best     <= acc;
              best_idx <= cmp_cls;
            end else if (acc > second) begin
              second   <= acc;
            end
            if (cmp_cls == CLS_LAST) state <= S_DONE;
          end
        end
        S_DONE: begin
          digit      <= 4'(best_idx);
          confidence <= (margin > SAT) ? 16'hFFFF : margin[15:0];
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_infer_seq_ctrl.sv
// Self-checking bench for infer_seq_ctrl: per-cycle comparison against a score/argmax model computed
// straight from the ROM contents and image, plus directed runs with hand-computed results.
module tb_infer_seq_ctrl;
  localparam int N_PIX   = 64;
  localparam int N_CLASS = 10;
  localparam int AW      = 10;
`ifdef INFER_BIAS_EN
  localparam int SUBS    = N_PIX + 1;
  localparam int LAT_LIT = 653;
  localparam int GAP_LIT = 654;
`else
  localparam int SUBS    = N_PIX;
  localparam int LAT_LIT = 643;
  localparam int GAP_LIT = 644;
`endif
  localparam int NISS    = N_CLASS * SUBS;
  localparam int LAT     = NISS + 3;
  localparam int ROM_SZ  = N_CLASS * N_PIX + N_CLASS;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [63:0]   im = '0;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_data = '0;
  logic          busy, done;
  logic [3:0]    digit;
  logic [15:0]   confidence;

  logic [7:0]    rom [ROM_SZ];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  infer_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .im(im), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .digit(digit), .confidence(confidence)
  );

  always #5 clk = ~clk;

  // Synchronous weight ROM: data one cycle after the address.
  always @(posedge clk) w_data <= rom[w_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected address of the k-th issued ROM read in a run.
  function automatic logic [AW-1:0] addr_k(input int k);
`ifdef INFER_BIAS_EN
    int c = k / SUBS;
    int s = k % SUBS;
    return (s == 0) ? AW'(N_CLASS * N_PIX + c) : AW'(c * N_PIX + s - 1);
`else
    return AW'(k);
`endif
  endfunction

  // Scores as plain integer sums, then argmax (lowest index on ties) and margin to the best of the rest.
  function automatic void model_result(input logic [63:0] img, output logic [3:0] d, output logic [15:0] m);
    int score [N_CLASS];
    int best_i;
    int sec;
    int s;
    logic signed [15:0] w16;
    for (int c = 0; c < N_CLASS; c++) begin
      s = 0;
`ifdef INFER_BIAS_EN
      s += $signed(rom[N_CLASS * N_PIX + c]);
`endif
      for (int p = 0; p < N_PIX; p++)
        if (img[p]) s += $signed(rom[c * N_PIX + p]);
      w16 = s[15:0];
      score[c] = w16;
    end
    best_i = 0;
    for (int c = 1; c < N_CLASS; c++)
      if (score[c] > score[best_i]) best_i = c;
    sec = -32768;
    for (int c = 0; c < N_CLASS; c++)
      if (c != best_i && score[c] > sec) sec = score[c];
    d = 4'(best_i);
    m = (score[best_i] - sec > 65535) ? 16'hFFFF : 16'(score[best_i] - sec);
  endfunction

  // Model of run timing and held outputs.
  int            cyc = 0;
  bit            run_act = 1'b0;
  int            s_edge = 0;
  logic [AW-1:0] m_addr = '0;
  logic [3:0]    m_digit = '0, pend_digit = '0;
  logic [15:0]   m_conf = '0, pend_conf = '0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      run_act = 1'b0;
      m_addr  = '0;
      m_digit = '0;
      m_conf  = '0;
    end else begin
      cyc++;
      if (run_act && cyc == s_edge + LAT) begin
        m_digit = pend_digit;
        m_conf  = pend_conf;
      end
      if (start && (!run_act || cyc > s_edge + LAT)) begin
        s_edge  = cyc;
        run_act = 1'b1;
        model_result(im, pend_digit, pend_conf);
      end
      if (run_act && cyc - s_edge < NISS) m_addr = addr_k(cyc - s_edge);
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("busy", busy, run_act && cyc >= s_edge && cyc < s_edge + LAT);
    check("done", done, run_act && cyc == s_edge + LAT);
    check("w_addr", w_addr, m_addr);
    check("digit", digit, m_digit);
    check("confidence", confidence, m_conf);
    if (done) done_cnt++;
  end

  task automatic run_case(input string name, input logic [63:0] img, input bit disturb,
                          input int exp_digit, input int exp_conf);
    int  t0, lat, dc0;
    bit  seen;
    dc0 = done_cnt;
    @(posedge clk); #2 im = img; start = 1'b1;
    @(posedge clk); #1 t0 = cyc; #1 start = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < LAT + 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end
      if (disturb && i == 98) begin #1 im = ~img; start = 1'b1; end
      if (disturb && i == 99) begin #1 start = 1'b0; end
    end
    check({name, " latency"}, seen ? lat : -1, LAT_LIT);
    check({name, " digit"}, digit, exp_digit);
    check({name, " confidence"}, confidence, exp_conf);
    repeat (3) @(posedge clk);
    #2 check({name, " done pulses"}, done_cnt - dc0, 1);
  endtask

  task automatic fill_rom(input int c_sel, input int w_sel, input int w_other);
    for (int a = 0; a < ROM_SZ; a++) rom[a] = 8'(w_other);
    for (int p = 0; p < N_PIX; p++) rom[c_sel * N_PIX + p] = 8'(w_sel);
    for (int c = 0; c < N_CLASS; c++) rom[N_CLASS * N_PIX + c] = 8'h00;
  endtask

  initial begin
    int dc0, d1, d2;
    for (int a = 0; a < ROM_SZ; a++) rom[a] = 8'h00;

    // Test 1: reset state, idle produces no done.
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("idle done count", done_cnt, 0);
    check("reset busy", busy, 0);
    check("reset digit", digit, 0);
    check("reset w_addr", w_addr, 0);

    // Test 2: class 3 has double weight -> 128 vs 64.
    fill_rom(3, 2, 1);
    run_case("t2", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3, 64);

    // Test 3: all classes equal -> lowest index wins, zero margin; empty image likewise.
    fill_rom(0, 5, 5);
    run_case("t3 tie", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0);
    run_case("t3 empty", 64'h0, 1'b0, 0, 0);

    // Test 4: class 7 scores 32, others 0; im toggle and start mid-run ignored.
    fill_rom(0, 0, 0);
    for (int p = 0; p < N_PIX; p++) rom[7 * N_PIX + p] = (p < 32) ? 8'h01 : 8'hFF;
    run_case("t4", 64'h0000_0000_FFFF_FFFF, 1'b1, 7, 32);

    // Test 5: abort at cycle 300 of a run; no done from it, rerun matches test 2.
    fill_rom(3, 2, 1);
    dc0 = done_cnt;
    @(posedge clk); #2 im = '1; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (299) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort w_addr", w_addr, 0);
    check("abort digit", digit, 0);
    check("abort confidence", confidence, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (LAT + 20) @(posedge clk);
    #2 check("abort no done", done_cnt - dc0, 0);
    run_case("t5 rerun", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3, 64);

    // Start held high re-triggers on the first idle cycle after done.
    d1 = -1;
    d2 = -1;
    @(posedge clk); #2 start = 1'b1;
    for (int i = 0; i < 2 * LAT + 50 && d2 < 0; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else begin
          d2 = cyc;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("held start gap", (d1 >= 0 && d2 >= 0) ? d2 - d1 : -1, GAP_LIT);

`ifdef INFER_BIAS_EN
    // Test 6: zero weights, bias[c] = c -> class 9 by one.
    fill_rom(0, 0, 0);
    for (int c = 0; c < N_CLASS; c++) rom[N_CLASS * N_PIX + c] = 8'(c);
    run_case("t6 bias", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 9, 1);
`endif

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
